// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_PRESCALE_W = 6;
    localparam int MIN_PRESCALE   = 4;

    localparam logic [3:0] START_BIT     = 4'd0;
    localparam logic [3:0] LAST_DATA_BIT = 4'd8;
    localparam logic [3:0] PAR_BIT       = 4'd9;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter; edge wraps at P-1 and carries into bit.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  last_edge
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic [PRESCALE_W-1:0] last_idx;

    assign last_idx  = prescale - 1'b1;
    assign last_edge = (edge_q == last_idx);

    // Clear wins over enable so the frame exit never leaves a stale bit index.
    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clr) begin
            edge_d = '0;
            bit_d  = START_BIT;
        end else if (en) begin
            if (last_edge) begin
                edge_d = '0;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q <= '0;
            bit_q  <= START_BIT;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt = edge_q;
    assign bit_cnt  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: walks start/data/parity/stop, strobes the datapath
// checkers and reports the frame verdict one cycle after the stop bit.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  sampled_bit,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  dat_samp_en,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam logic [3:0] LAST_BIT = START_BIT + 4'(DATA_W);

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  par_en_q, par_en_d;
    logic                  par_flag_q, par_flag_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  last_edge;
    logic                  cnt_clr;
    logic                  start_ok;

    // The sampled data path goes straight to the deserializer, not through here.
    logic unused_sampled_bit;
    assign unused_sampled_bit = sampled_bit;

    assign start_ok = !RX_IN && (Prescale >= PRESCALE_W'(MIN_PRESCALE));
    assign cnt_clr  = (state_d == IDLE);

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (!cnt_clr),
        .clr       (cnt_clr),
        .prescale  (p_q),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // infer a latch.
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        par_en_d     = par_en_q;
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        dat_samp_en  = (state_q != IDLE);
        deser_en     = 1'b0;
        strt_chk_en  = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    p_d        = Prescale;
                    par_en_d   = PAR_EN;
                    par_flag_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (last_edge) begin
                    strt_chk_en = 1'b1;
                    state_d     = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                if (last_edge) begin
                    deser_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                // Even a failed parity bit moves on to STOP to stay frame-aligned.
                if (last_edge) begin
                    par_chk_en = 1'b1;
                    par_flag_d = par_flag_q | par_err;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    stp_chk_en = 1'b1;
                    state_d    = IDLE;
                    if (par_flag_q || stp_err) begin
                        frame_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            p_q          <= '0;
            par_en_q     <= 1'b0;
            par_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            par_en_q     <= par_en_d;
            par_flag_q   <= par_flag_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus queues expected strobe/verdict
// events with their cycle, a negedge monitor pops and compares them.
module tb_uart_rx_ctrl;

    localparam int PW = 6;

    typedef enum int {
        EV_STRT  = 0,
        EV_DESER = 1,
        EV_PAR   = 2,
        EV_STP   = 3,
        EV_VALID = 4,
        EV_FERR  = 5
    } ev_e;

    typedef struct {
        ev_e kind;
        int  cyc;
        int  bitn;
        int  edgen;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] Prescale;
    logic          sampled_bit;
    logic          strt_glitch;
    logic          par_err;
    logic          stp_err;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    ev_t  q[$];
    ev_t  mon_ev;
    logic [5:0] mon_act;

    uart_rx_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .sampled_bit (sampled_bit),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_act = {frame_err, data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
            for (int k = 0; k < 6; k++) begin
                if (mon_act[k]) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
                    end else begin
                        mon_ev = q.pop_front();
                        check("event_kind", k, int'(mon_ev.kind));
                        check("event_cycle", cyc, mon_ev.cyc);
                        if (k < 4) begin
                            check("event_bit_cnt", 32'(bit_cnt), mon_ev.bitn);
                            check("event_edge_cnt", 32'(edge_cnt), mon_ev.edgen);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        step(n);
    endtask

    // Drives one frame starting in the current cycle and queues every event it implies.
    task automatic send_frame(input int p, input bit pe, input bit glitch, input bit perr,
                              input bit serr, input logic [7:0] data, input int chg);
        int t0;
        int sb;
        logic bv;
        t0          = cyc;
        Prescale    = PW'(p);
        PAR_EN      = pe;
        strt_glitch = glitch;
        par_err     = perr;
        stp_err     = serr;
        q.push_back('{EV_STRT, t0 + p - 1, 0, p - 1});
        if (glitch) begin
            for (int c = 0; c < p; c++) begin
                RX_IN = (c < 3) ? 1'b0 : 1'b1;
                step(1);
            end
            return;
        end
        for (int k = 1; k <= 8; k++) q.push_back('{EV_DESER, t0 + (k + 1) * p - 1, k, p - 1});
        if (pe) q.push_back('{EV_PAR, t0 + 10 * p - 1, 9, p - 1});
        sb = pe ? 10 : 9;
        q.push_back('{EV_STP, t0 + (sb + 1) * p - 1, sb, p - 1});
        q.push_back('{(perr || serr) ? EV_FERR : EV_VALID, t0 + (sb + 1) * p, 0, 0});
        for (int b = 0; b <= sb; b++) begin
            if (b == 0)           bv = 1'b0;
            else if (b <= 8)      bv = data[b-1];
            else if (pe && b == 9) bv = ^data;
            else                  bv = 1'b1;
            RX_IN       = bv;
            sampled_bit = bv;
            for (int c = 0; c < p; c++) begin
                step(1);
                if (chg != 0 && b == 0 && c == 0) Prescale = PW'(chg);
            end
        end
    endtask

    initial begin
        int t0;
        rst         = 1'b0;
        RX_IN       = 1'b1;
        PAR_EN      = 1'b0;
        Prescale    = PW'(8);
        sampled_bit = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        #1;
        check("reset_outputs", 32'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
              par_chk_en, stp_chk_en, data_valid, frame_err, busy}), 0);
        step(2);
        rst = 1'b1;
        idle(5);
        check("idle_after_reset_busy", 32'(busy), 0);

        // Reset in the middle of a frame: only the start strobe may appear before it.
        t0 = cyc;
        q.push_back('{EV_STRT, t0 + 7, 0, 7});
        RX_IN = 1'b0;
        step(1);
        RX_IN = 1'b1;
        step(11);
        check("midframe_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("midframe_reset_outputs", 32'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
              par_chk_en, stp_chk_en, data_valid, frame_err, busy}), 0);
        step(3);
        rst = 1'b1;
        idle(30);
        check("post_reset_idle_busy", 32'(busy), 0);

        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h45, 0);
        idle(4);
        send_frame(16, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA8, 0);
        idle(3);
        send_frame(16, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA8, 0);
        idle(3);
        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 0);
        idle(2);

        send_frame(8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_edge_cnt", 32'(edge_cnt), 0);
        idle(5);

        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 0);
        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
        idle(3);

        Prescale = PW'(0);
        RX_IN    = 1'b0;
        step(20);
        check("p0_busy", 32'(busy), 0);
        check("p0_edge_cnt", 32'(edge_cnt), 0);
        idle(3);

        send_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 16);
        idle(5);

        for (int i = 0; i < 300 && q.size() != 0; i++) step(1);
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
